// File: rtl/muldiv_seq_pkg.sv
// Shared op encodings, FSM state codes and op decode for the iterative RV64M multiply/divide unit.
package muldiv_seq_pkg;

    localparam int MDU_OP_WIDTH = 4;

    typedef enum logic [MDU_OP_WIDTH-1:0] {
        OP_MUL    = 4'd0,
        OP_MULH   = 4'd1,
        OP_MULHSU = 4'd2,
        OP_MULHU  = 4'd3,
        OP_DIV    = 4'd4,
        OP_DIVU   = 4'd5,
        OP_REM    = 4'd6,
        OP_REMU   = 4'd7,
        OP_MULW   = 4'd8,
        OP_DIVW   = 4'd9,
        OP_DIVUW  = 4'd10,
        OP_REMW   = 4'd11,
        OP_REMUW  = 4'd12
    } mdu_op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef struct packed {
        logic is_div;
        logic is_word;
        logic a_sgn;
        logic b_sgn;
        logic sel_hi;
        logic sel_rem;
    } op_dec_t;

    // MUL and MULW only need low product bits, so they run unsigned.
    function automatic op_dec_t op_decode(input mdu_op_e op);
        op_dec_t d;
        d = '0;
        case (op)
            OP_MULH:   begin d.sel_hi = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            OP_MULHSU: begin d.sel_hi = 1'b1; d.a_sgn = 1'b1; end
            OP_MULHU:  begin d.sel_hi = 1'b1; end
            OP_DIV:    begin d.is_div = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            OP_DIVU:   begin d.is_div = 1'b1; end
            OP_REM:    begin d.is_div = 1'b1; d.sel_rem = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            OP_REMU:   begin d.is_div = 1'b1; d.sel_rem = 1'b1; end
            OP_MULW:   begin d.is_word = 1'b1; end
            OP_DIVW:   begin d.is_div = 1'b1; d.is_word = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            OP_DIVUW:  begin d.is_div = 1'b1; d.is_word = 1'b1; end
            OP_REMW:   begin d.is_div = 1'b1; d.is_word = 1'b1; d.sel_rem = 1'b1; d.a_sgn = 1'b1; d.b_sgn = 1'b1; end
            OP_REMUW:  begin d.is_div = 1'b1; d.is_word = 1'b1; d.sel_rem = 1'b1; end
            default:   ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide datapath: operand magnitudes, 128-bit acc ({rem,quo} for divide),
// sign fixup and special-case forcing. One step per cycle when step is high; res is combinational.
module muldiv_datapath
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        step,
    input  logic        is_div,
    input  logic        is_word,
    input  logic        a_sgn,
    input  logic        b_sgn,
    input  logic        sel_hi,
    input  logic        sel_rem,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        special,
    output logic [63:0] res
);

    logic [127:0] acc_q, acc_d;
    logic [63:0]  opb_q, opb_d;
    logic [63:0]  dvd_q, dvd_d;
    logic         neg_res_q, neg_res_d;
    logic         neg_rem_q, neg_rem_d;
    logic         dz_q, dz_d;
    logic         ovf_q, ovf_d;

    logic [63:0]  a_ext, b_ext, a_mag, b_mag, rem_nx;
    logic         a_neg, b_neg, dz, ovf, ge;
    logic [64:0]  rem_sh, sum;

    always_comb begin
        a_ext  = is_word ? {{32{a_sgn & a[31]}}, a[31:0]} : a;
        b_ext  = is_word ? {{32{b_sgn & b[31]}}, b[31:0]} : b;
        a_neg  = a_sgn & a_ext[63];
        b_neg  = b_sgn & b_ext[63];
        a_mag  = a_neg ? (64'd0 - a_ext) : a_ext;
        b_mag  = b_neg ? (64'd0 - b_ext) : b_ext;
        dz     = is_div & (b_ext == 64'd0);
        ovf    = is_div & a_sgn & b_sgn & (b_ext == {64{1'b1}}) &
                 (a_ext == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        rem_sh = {acc_q[127:64], acc_q[63]};
        ge     = rem_sh >= {1'b0, opb_q};
        rem_nx = ge ? (rem_sh[63:0] - opb_q) : rem_sh[63:0];
        sum    = {1'b0, acc_q[127:64]} + (acc_q[0] ? {1'b0, opb_q} : 65'd0);
    end

    // Word divides pre-shift the dividend to the top so 32 steps consume exactly its bits.
    always_comb begin
        acc_d     = acc_q;
        opb_d     = opb_q;
        dvd_d     = dvd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        if (start) begin
            acc_d     = is_div ? {64'd0, (is_word ? {a_mag[31:0], 32'd0} : a_mag)} : {64'd0, b_mag};
            opb_d     = is_div ? b_mag : a_mag;
            dvd_d     = a_ext;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = dz;
            ovf_d     = ovf;
        end else if (step) begin
            acc_d = is_div ? {rem_nx, acc_q[62:0], ge} : {sum, acc_q[63:1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q     <= '0;
            opb_q     <= '0;
            dvd_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            dvd_q     <= dvd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign special = dz_q | ovf_q;

    logic [127:0] prod;
    logic [63:0]  quo, rem, raw;

    // A 32-step right-shift multiply leaves the word product's low half at acc[63:32].
    always_comb begin
        prod = neg_res_q ? (128'd0 - acc_q) : acc_q;
        quo  = neg_res_q ? (64'd0 - acc_q[63:0]) : acc_q[63:0];
        rem  = neg_rem_q ? (64'd0 - acc_q[127:64]) : acc_q[127:64];
        if (is_div) begin
            raw = sel_rem ? rem : quo;
            if (dz_q)
                raw = sel_rem ? dvd_q : {64{1'b1}};
            else if (ovf_q)
                raw = sel_rem ? 64'd0 : dvd_q;
        end else begin
            raw = is_word ? {32'd0, acc_q[63:32]} : (sel_hi ? prod[127:64] : prod[63:0]);
        end
        res = is_word ? {{32{raw[31]}}, raw[31:0]} : raw;
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide sequencer beside the EX ALU; result after 1+N cycles (N=64, 32 for word ops),
// 1 cycle for early-out divide special cases. Single request in flight; result held in DONE until out_ready.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int EARLY_OUT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MDU_OP_WIDTH-1:0] op,
    input  logic [XLEN-1:0]         a,
    input  logic [XLEN-1:0]         b,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         result,
    output logic                    busy
);

    logic [1:0]      state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    mdu_op_e         op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] dp_res;
    logic            start, step, special;
    logic [6:0]      n_iter;
    op_dec_t         dec_in, dec_q, dec;

    assign start  = in_valid && (state_q == ST_IDLE) && !flush;
    assign dec_in = op_decode(mdu_op_e'(op));
    assign dec_q  = op_decode(op_q);
    assign dec    = start ? dec_in : dec_q;
    assign n_iter = dec_q.is_word ? 7'd32 : 7'd64;

    // The cycle after the last step latches the fixed-up result, hence 1+N to out_valid.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        step     = 1'b0;
        if (flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_d    = mdu_op_e'(op);
                        cnt_d   = '0;
                        state_d = dec_in.is_div ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (((EARLY_OUT != 0) && (state_q == ST_DIV) && special) || (cnt_q == n_iter)) begin
                        result_d = dp_res;
                        cnt_d    = '0;
                        state_d  = ST_DONE;
                    end else begin
                        step  = 1'b1;
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    muldiv_datapath u_dp (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .step    (step),
        .is_div  (dec.is_div),
        .is_word (dec.is_word),
        .a_sgn   (dec.a_sgn),
        .b_sgn   (dec.b_sgn),
        .sel_hi  (dec.sel_hi),
        .sel_rem (dec.sel_rem),
        .a       (a),
        .b       (b),
        .special (special),
        .res     (dp_res)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: arithmetic reference model plus one per-cycle compare process, directed vectors.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t q[$];
    bit   head_seen = 1'b0;
    bit   pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        logic signed [63:0]  sx, sy, sq;
        logic signed [127:0] px, py, pyu;
        logic [127:0]        ux, uy, up;
        logic signed [31:0]  wx, wy, wq;
        logic [31:0]         vx, vy;
        logic [63:0]         r;
        sx = x; sy = y; px = sx; py = sy; pyu = {64'd0, y};
        ux = {64'd0, x}; uy = {64'd0, y};
        wx = x[31:0]; wy = y[31:0]; vx = x[31:0]; vy = y[31:0];
        r = 64'd0;
        case (o)
            OP_MUL:    r = x * y;
            OP_MULH:   begin up = px * py;  r = up[127:64]; end
            OP_MULHSU: begin up = px * pyu; r = up[127:64]; end
            OP_MULHU:  begin up = ux * uy;  r = up[127:64]; end
            OP_DIV: begin
                if (y == 64'd0) r = ONES;
                else if (x == MINV && y == ONES) r = x;
                else begin sq = sx / sy; r = sq; end
            end
            OP_REM: begin
                if (y == 64'd0) r = x;
                else if (x == MINV && y == ONES) r = 64'd0;
                else begin sq = sx % sy; r = sq; end
            end
            OP_DIVU:   r = (y == 64'd0) ? ONES : x / y;
            OP_REMU:   r = (y == 64'd0) ? x : x % y;
            OP_MULW:   r = sx32(vx * vy);
            OP_DIVW: begin
                if (vy == 32'd0) r = ONES;
                else if (vx == 32'h8000_0000 && vy == 32'hFFFF_FFFF) r = sx32(vx);
                else begin wq = wx / wy; r = sx32(wq); end
            end
            OP_REMW: begin
                if (vy == 32'd0) r = sx32(vx);
                else if (vx == 32'h8000_0000 && vy == 32'hFFFF_FFFF) r = 64'd0;
                else begin wq = wx % wy; r = sx32(wq); end
            end
            OP_DIVUW:  r = (vy == 32'd0) ? ONES : sx32(vx / vy);
            OP_REMUW:  r = (vy == 32'd0) ? sx32(vx) : sx32(vx % vy);
            default:   r = x * y;
        endcase
        return r;
    endfunction

    // Cycles from the accept edge to out_valid, with early-out enabled.
    function automatic int exp_lat(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        bit word, isdiv, sdiv, bz, ov;
        word  = (o >= 4'd8);
        isdiv = (o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW});
        sdiv  = (o inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW});
        if (word) begin
            bz = (y[31:0] == 32'd0);
            ov = sdiv && x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF;
        end else begin
            bz = (y == 64'd0);
            ov = sdiv && x == MINV && y == ONES;
        end
        if (isdiv && (bz || ov)) return 1;
        return word ? 33 : 65;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            chk("busy_vs_in_ready", {63'd0, busy}, {63'd0, ~in_ready});
            if (pend) begin
                chk("valid_after_end", {63'd0, out_valid}, 64'd0);
                chk("ready_after_end", {63'd0, in_ready}, 64'd1);
                if (q.size() > 0) void'(q.pop_front());
                head_seen = 1'b0;
            end else if (q.size() == 0) begin
                chk("no_spurious_valid", {63'd0, out_valid}, 64'd0);
            end else begin
                e = q[0];
                if (out_valid) begin
                    if (!head_seen) begin
                        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                        head_seen = 1'b1;
                    end
                    chk("result", result, e.res);
                    chk("in_ready_in_done", {63'd0, in_ready}, 64'd0);
                end else if (head_seen) begin
                    chk("valid_dropped", {63'd0, out_valid}, 64'd1);
                end else if (cyc == e.acc + e.lat) begin
                    chk("valid_on_time", {63'd0, out_valid}, 64'd1);
                end
            end
            pend = (out_valid && out_ready) || flush;
        end
    end

    task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
        exp_t e;
        chk("in_ready_before_req", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        e.res = model(o, x, y);
        e.acc = cyc + 1;
        e.lat = exp_lat(o, x, y);
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y, input int hold);
        int n;
        issue(o, x, y);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL wait_valid: no out_valid after %0d cycles, op %0d", n, o);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
        end else begin
            repeat (hold) begin @(posedge clk); #1; end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", result, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        chk("pin_mul", model(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("pin_mulhu", model(OP_MULHU, ONES, ONES), 64'hFFFF_FFFF_FFFF_FFFE);
        chk("pin_div", model(OP_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("pin_rem", model(OP_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2), ONES);
        chk("pin_divw", model(OP_DIVW, 64'h1_0000_0064, 64'd5), 64'd20);
        chk("pin_divu0", model(OP_DIVU, 64'd123, 64'd0), ONES);
        chk("pin_remu0", model(OP_REMU, 64'd123, 64'd0), 64'd123);
        chk("pin_divovf", model(OP_DIV, MINV, ONES), MINV);
        chk("pin_removf", model(OP_REM, MINV, ONES), 64'd0);
        chk("pin_mulhsu", model(OP_MULHSU, ONES, 64'd2), ONES);
        chk("pin_mulw", model(OP_MULW, 64'd3, 64'hFFFF_FFFE), 64'hFFFF_FFFF_FFFF_FFFA);
        chk("pin_remuw0", model(OP_REMUW, 64'h8000_0001, 64'd0), 64'hFFFF_FFFF_8000_0001);

        run(OP_MUL,    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run(OP_MULHU,  ONES, ONES, 0);
        run(OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        run(OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0);
        run(OP_DIVW,   64'h1_0000_0064, 64'd5, 0);
        run(OP_DIVU,   64'd123, 64'd0, 0);
        run(OP_REMU,   64'd123, 64'd0, 0);
        run(OP_DIV,    MINV, ONES, 0);
        run(OP_REM,    MINV, ONES, 0);
        run(OP_MULH,   64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 0);
        run(OP_MULHSU, ONES, 64'd2, 0);
        run(OP_MULH,   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0);
        run(OP_MUL,    64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 0);
        run(OP_MULW,   64'd3, 64'hFFFF_FFFE, 0);
        run(OP_REM,    64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 0);
        run(OP_DIVU,   ONES, 64'd10, 0);
        run(OP_DIVW,   64'hFFFF_FF9C, 64'd7, 0);
        run(OP_REMW,   64'hFFFF_FF9C, 64'd7, 0);
        run(OP_DIVUW,  64'hFFFF_FFFF, 64'd1, 0);
        run(OP_REMUW,  64'h8000_0001, 64'd0, 0);
        run(OP_DIVW,   64'h8000_0000, 64'hFFFF_FFFF, 0);
        run(OP_REMW,   64'h8000_0000, 64'hFFFF_FFFF, 0);

        // Backpressure: result must hold for 5 cycles with in_ready low.
        run(OP_MULHSU, 64'h8000_0000_0000_0001, ONES, 5);

        // flush together with in_valid in IDLE must not start anything.
        in_valid = 1'b1; flush = 1'b1; op = OP_MUL; a = 64'd1; b = 64'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", {63'd0, busy}, 64'd0);

        // flush during iteration 30 of a DIV, then a clean MUL.
        issue(OP_DIV, 64'd1000, 64'd7);
        repeat (29) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_idle", {63'd0, in_ready}, 64'd1);
        repeat (80) begin @(posedge clk); #1; end
        run(OP_MUL, 64'd12345, 64'd6789, 0);

        // Asynchronous reset between edges in the middle of a MUL.
        issue(OP_MULHU, 64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0003);
        repeat (20) begin @(posedge clk); #1; end
        #2;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_result", result, 64'd0);
        q.delete();
        head_seen = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        run(OP_MULH, 64'hFFFF_FFFF_FFFF_FF00, 64'd77, 0);

        repeat (3) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative RV64M multiply/divide unit with FSM sequencer, placed beside the ALU in EX. It takes the operand pair A/B already chosen by the ALU operand muxes, runs a shift-add multiply or restoring divide over multiple cycles, and returns one registered 64-bit result. Handshakes are valid/ready on both sides. The pipeline control uses `busy` to stall EX.

Parameters:
XLEN, 64, operand/result width; only 64 is supported, word ops use XLEN/2.
EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow cases skip iteration.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  request valid.
in_ready  out  1  unit can accept a request (state IDLE).
op  in  4  MDU op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
a  in  64  operand A (rs1 value).
b  in  64  operand B (rs2 value).
flush  in  1  synchronous kill of any in-flight op.
out_valid  out  1  result valid.
out_ready  in  1  consumer takes the result.
result  out  64  registered result.
busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (reset==0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, iteration counter=0. This applies at any time, including mid-iteration.
- Accept when in_valid && in_ready && !flush. Latch op and the operands (word ops take bits [31:0]), then go to MUL or DIV.
- Signed ops: take magnitudes of the signed operands and record the result sign(s). MULHSU treats only a as signed.
- MUL state: one shift-add step per cycle into a 128-bit accumulator. The counter runs 64 cycles (32 for MULW). At the end, negate the accumulator if the signs differ.
- DIV state: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). The counter runs 64 cycles (32 for word ops). At the end, apply sign fixup: quotient negated if the signs differ; remainder takes the dividend's sign.
- Result selection:
  - MUL: low 64 bits.
  - MULH*: high 64 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Word ops: low 32 bits sign-extended to 64, including DIVUW/REMUW.
- Divide by zero: quotient = all ones; remainder = dividend (for word ops, the sign-extended 32-bit dividend).
- Signed overflow (dividend = most-negative value, divisor = -1): quotient = dividend, remainder = 0.
- With EARLY_OUT=1, both special cases go straight to DONE in the cycle after accept. With EARLY_OUT=0, they iterate normally and the fixup still forces the values above.
- Latency from the accept edge T:
  - out_valid rises at T+1+N, N = 64 (32 for word ops).
  - Special cases with EARLY_OUT=1: out_valid rises at T+1.
- DONE: out_valid=1 and result is held stable until out_ready. On out_valid && out_ready, go to IDLE next cycle. No new request is accepted in that same cycle.
- flush: from any state, go to IDLE next cycle, drop out_valid, and discard the result. flush wins over in_valid and over out_ready in the same cycle.
- in_valid while busy: ignored; the requester holds it.
- Counter: 7 bits, no wrap. The terminal count triggers the final-step transition exactly once.

Decomposition:
- defines.sv: MDU_OP_WIDTH, the 13 op encodings, and state encodings.
- common.sv: a typedef for the mdu op enum.
- One sub-module, muldiv_datapath: holds the accumulator/remainder/quotient registers and the step logic. It is controlled by `start`, `step`, `is_div`, and `is_word` from the FSM in muldiv_seq.

Test Plan:
1. MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB, out_valid at T+65. Then MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE.
2. DIV a=-7, b=2 -> quotient 0xFFFF_FFFF_FFFF_FFFD. REM on the same operands -> 0xFFFF_FFFF_FFFF_FFFF. DIVW a=0x1_0000_0064, b=5 -> 20, out_valid at T+33.
3. DIVU a=123, b=0 -> all ones; REMU a=123, b=0 -> 123; with EARLY_OUT=1, out_valid at T+1. DIV a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000; REM on the same operands -> 0.
4. Backpressure: out_ready held at 0 for 5 cycles in DONE -> result stable and in_ready=0 throughout. out_ready=1 -> IDLE next cycle, in_ready=1.
5. flush asserted on iteration 30 of a DIV -> IDLE next cycle, out_valid never rises. A new MUL accepted next is correct.
6. reset driven low mid-MUL (asynchronous, between edges) -> all outputs reach reset values immediately. After release, the first request completes correctly.
